// File: rtl/vga_timing_ctrl_pkg.sv
// Shared definitions for the VGA timing controller.
//   phase_e     : scan phase encoding used by both the H and V sequencers
//   Def*        : 640x480@60 timing defaults (pixels for H, lines for V)
//   next_phase  : ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE successor
package vga_timing_ctrl_pkg;

   typedef enum logic [1:0] {
      PhActive = 2'd0,
      PhFront  = 2'd1,
      PhSync   = 2'd2,
      PhBack   = 2'd3
   } phase_e;

   localparam int unsigned DefHActive = 640;
   localparam int unsigned DefHFp     = 16;
   localparam int unsigned DefHSync   = 96;
   localparam int unsigned DefHBp     = 48;
   localparam int unsigned DefVActive = 480;
   localparam int unsigned DefVFp     = 10;
   localparam int unsigned DefVSync   = 2;
   localparam int unsigned DefVBp     = 33;
   localparam int unsigned DefCw      = 10;

   // The encoding is a plain 2-bit count, so the successor wraps BACK back to ACTIVE.
   function automatic phase_e next_phase(input phase_e p);
      return phase_e'(p + 2'd1);
   endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel-side bundle of the VGA timing controller.
//   i_sclr, i_pix_en               : restart / pixel tick into the controller
//   o_hsync, o_vsync, o_de         : sync and data-enable to the RGB stage
//   o_x, o_y                       : active-area coordinates (0 in blanking)
//   o_line_end, o_frame_start      : per-tick strobes
// modport master: the timing controller; modport slave: its driver / consumer.
interface vga_timing_ctrl_if
   import vga_timing_ctrl_pkg::*;
#(
   parameter int unsigned CW = DefCw
);
   logic          i_sclr;
   logic          i_pix_en;
   logic          o_hsync;
   logic          o_vsync;
   logic          o_de;
   logic [CW-1:0] o_x;
   logic [CW-1:0] o_y;
   logic          o_line_end;
   logic          o_frame_start;

   modport master (
      input  i_sclr, i_pix_en,
      output o_hsync, o_vsync, o_de, o_x, o_y, o_line_end, o_frame_start
   );

   modport slave (
      output i_sclr, i_pix_en,
      input  o_hsync, o_vsync, o_de, o_x, o_y, o_line_end, o_frame_start
   );
endinterface

// File: rtl/vga_phase_fsm.sv
// Generic four-phase sequencer (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE).
//   clk, i_rst : clock, asynchronous active-high reset
//   i_sclr     : synchronous return to (ACTIVE, 0); overrides i_step
//   i_step     : advance one position
//   o_phase    : current phase (registered)
//   o_cnt      : position within the phase (registered, clears on every transition)
//   o_last     : o_cnt is the last position of the current phase
module vga_phase_fsm
   import vga_timing_ctrl_pkg::*;
#(
   parameter int unsigned LEN_ACTIVE = DefHActive,
   parameter int unsigned LEN_FRONT  = DefHFp,
   parameter int unsigned LEN_SYNC   = DefHSync,
   parameter int unsigned LEN_BACK   = DefHBp,
   parameter int unsigned CW         = DefCw
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          i_sclr,
   input  logic          i_step,
   output phase_e        o_phase,
   output logic [CW-1:0] o_cnt,
   output logic          o_last
);

   localparam logic [CW-1:0] LastActive = CW'(LEN_ACTIVE - 1);
   localparam logic [CW-1:0] LastFront  = CW'(LEN_FRONT - 1);
   localparam logic [CW-1:0] LastSync   = CW'(LEN_SYNC - 1);
   localparam logic [CW-1:0] LastBack   = CW'(LEN_BACK - 1);

   phase_e        phase_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] last_cnt;

   always_comb begin
      last_cnt = LastActive;
      unique case (phase_q)
         PhActive: last_cnt = LastActive;
         PhFront:  last_cnt = LastFront;
         PhSync:   last_cnt = LastSync;
         PhBack:   last_cnt = LastBack;
         default:  last_cnt = LastActive;
      endcase
   end

   // A length of 1 gives last_cnt = 0, so every step leaves the phase.
   assign o_last = (cnt_q == last_cnt);

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         phase_q <= PhActive;
         cnt_q   <= '0;
      end else if (i_sclr) begin
         phase_q <= PhActive;
         cnt_q   <= '0;
      end else if (i_step) begin
         if (o_last) begin
            phase_q <= next_phase(phase_q);
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign o_phase = phase_q;
   assign o_cnt   = cnt_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing generator.
//   clk   : system clock
//   i_rst : asynchronous active-high reset
//   bus   : vga_timing_ctrl_if.master -- i_sclr / i_pix_en in; sync, de, coordinates and
//           line/frame strobes out
// The horizontal sequencer steps on each pixel tick; the vertical sequencer steps on the
// last back-porch pixel of each line, so vsync edges fall on line boundaries.
module vga_timing_ctrl
   import vga_timing_ctrl_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DefHActive,
   parameter int unsigned H_FP     = DefHFp,
   parameter int unsigned H_SYNC   = DefHSync,
   parameter int unsigned H_BP     = DefHBp,
   parameter int unsigned V_ACTIVE = DefVActive,
   parameter int unsigned V_FP     = DefVFp,
   parameter int unsigned V_SYNC   = DefVSync,
   parameter int unsigned V_BP     = DefVBp,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned CW       = DefCw
) (
   input logic               clk,
   input logic               i_rst,
   vga_timing_ctrl_if.master bus
);

   phase_e        h_phase;
   phase_e        v_phase;
   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          h_last;
   logic          v_last_unused;
   logic          line_end;

   vga_phase_fsm #(
      .LEN_ACTIVE (H_ACTIVE),
      .LEN_FRONT  (H_FP),
      .LEN_SYNC   (H_SYNC),
      .LEN_BACK   (H_BP),
      .CW         (CW)
   ) u_h_fsm (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_sclr  (bus.i_sclr),
      .i_step  (bus.i_pix_en),
      .o_phase (h_phase),
      .o_cnt   (h_cnt),
      .o_last  (h_last)
   );

   assign line_end = bus.i_pix_en && (h_phase == PhBack) && h_last;

   vga_phase_fsm #(
      .LEN_ACTIVE (V_ACTIVE),
      .LEN_FRONT  (V_FP),
      .LEN_SYNC   (V_SYNC),
      .LEN_BACK   (V_BP),
      .CW         (CW)
   ) u_v_fsm (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_sclr  (bus.i_sclr),
      .i_step  (line_end),
      .o_phase (v_phase),
      .o_cnt   (v_cnt),
      .o_last  (v_last_unused)
   );

   // Decoded from the phase registers only; no dependence on the pixel tick.
   assign bus.o_hsync = (h_phase == PhSync) ? SYNC_POL : ~SYNC_POL;
   assign bus.o_vsync = (v_phase == PhSync) ? SYNC_POL : ~SYNC_POL;
   assign bus.o_de    = (h_phase == PhActive) && (v_phase == PhActive);
   assign bus.o_x     = (h_phase == PhActive) ? h_cnt : '0;
   assign bus.o_y     = (v_phase == PhActive) ? v_cnt : '0;

   assign bus.o_line_end    = line_end;
   assign bus.o_frame_start = bus.i_pix_en && (h_phase == PhActive) && (v_phase == PhActive)
                              && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl. Three instances share clk/rst/sclr/pix_en:
//   0: default 640x480 timing, 1: tiny 4/1/1/1 x 2/1/1/1 with active-high sync,
//   2: medium 20/3/5/4 x 6/2/2/3 (full frames within a short run).
// The reference model tracks a linear scan position (h, v) per instance and derives
// every output from the position ranges of each phase.
module tb_vga_timing_ctrl;

   typedef struct {
      int ha, hfp, hs, hbp;
      int va, vfp, vs, vbp;
      bit pol;
   } tim_t;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       de;
      logic [9:0] x;
      logic [9:0] y;
      logic       line_end;
      logic       frame_start;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclr = 1'b0;
   logic pe = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   tim_t tm[3];
   int   hp[3];
   int   vp[3];
   obs_t q0[$];
   obs_t q1[$];
   obs_t q2[$];

   always #5 clk = ~clk;

   vga_timing_ctrl_if #(.CW(10)) bus0 ();
   vga_timing_ctrl_if #(.CW(10)) bus1 ();
   vga_timing_ctrl_if #(.CW(10)) bus2 ();

   assign bus0.i_sclr = sclr;
   assign bus1.i_sclr = sclr;
   assign bus2.i_sclr = sclr;
   assign bus0.i_pix_en = pe;
   assign bus1.i_pix_en = pe;
   assign bus2.i_pix_en = pe;

   vga_timing_ctrl u_dut0 (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus0)
   );

   vga_timing_ctrl #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
      .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (1'b1), .CW (10)
   ) u_dut1 (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus1)
   );

   vga_timing_ctrl #(
      .H_ACTIVE (20), .H_FP (3), .H_SYNC (5), .H_BP (4),
      .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3),
      .SYNC_POL (1'b0), .CW (10)
   ) u_dut2 (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus2)
   );

   function automatic obs_t model(input tim_t t, input int h, input int v, input bit tick);
      obs_t o;
      int   ht;
      int   hs0;
      int   vs0;
      ht  = t.ha + t.hfp + t.hs + t.hbp;
      hs0 = t.ha + t.hfp;
      vs0 = t.va + t.vfp;
      o.de          = (h < t.ha) && (v < t.va);
      o.x           = (h < t.ha) ? 10'(h) : 10'd0;
      o.y           = (v < t.va) ? 10'(v) : 10'd0;
      o.hsync       = (h >= hs0 && h < hs0 + t.hs) ? t.pol : !t.pol;
      o.vsync       = (v >= vs0 && v < vs0 + t.vs) ? t.pol : !t.pol;
      o.line_end    = tick && (h == ht - 1);
      o.frame_start = tick && (h == 0) && (v == 0);
      return o;
   endfunction

   // Apply the inputs of the cycle that just ended to the model positions.
   task automatic advance();
      for (int i = 0; i < 3; i++) begin
         if (sclr) begin
            hp[i] = 0;
            vp[i] = 0;
         end else if (pe) begin
            hp[i]++;
            if (hp[i] == tm[i].ha + tm[i].hfp + tm[i].hs + tm[i].hbp) begin
               hp[i] = 0;
               vp[i]++;
               if (vp[i] == tm[i].va + tm[i].vfp + tm[i].vs + tm[i].vbp) vp[i] = 0;
            end
         end
      end
   endtask

   task automatic push_all();
      q0.push_back(model(tm[0], hp[0], vp[0], pe));
      q1.push_back(model(tm[1], hp[1], vp[1], pe));
      q2.push_back(model(tm[2], hp[2], vp[2], pe));
   endtask

   task automatic step(input bit pe_v, input bit sc_v);
      @(posedge clk);
      #1;
      advance();
      pe   = pe_v;
      sclr = sc_v;
      push_all();
   endtask

   task automatic chk(input string name, input obs_t got, input obs_t want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d le=%b fs=%b want hs=%b vs=%b de=%b x=%0d y=%0d le=%b fs=%b",
                  name, $time, got.hsync, got.vsync, got.de, got.x, got.y, got.line_end,
                  got.frame_start, want.hsync, want.vsync, want.de, want.x, want.y,
                  want.line_end, want.frame_start);
      end
   endtask

   // Monitor: outputs are valid every cycle, so each pushed expectation is checked on the
   // falling edge of the cycle it describes.
   always @(negedge clk) begin
      if (q0.size() > 0)
         chk("dut0", {bus0.o_hsync, bus0.o_vsync, bus0.o_de, bus0.o_x, bus0.o_y,
                      bus0.o_line_end, bus0.o_frame_start}, q0.pop_front());
      if (q1.size() > 0)
         chk("dut1", {bus1.o_hsync, bus1.o_vsync, bus1.o_de, bus1.o_x, bus1.o_y,
                      bus1.o_line_end, bus1.o_frame_start}, q1.pop_front());
      if (q2.size() > 0)
         chk("dut2", {bus2.o_hsync, bus2.o_vsync, bus2.o_de, bus2.o_x, bus2.o_y,
                      bus2.o_line_end, bus2.o_frame_start}, q2.pop_front());
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t bench did not finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tm[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      tm[1] = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b1};
      tm[2] = '{20, 3, 5, 4, 6, 2, 2, 3, 1'b0};
      for (int i = 0; i < 3; i++) begin
         hp[i] = 0;
         vp[i] = 0;
      end

      // Reset state with the tick low.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      push_all();
      repeat (4) step(1'b0, 1'b0);

      // Continuous ticks: several lines at default timing, many full tiny/medium frames.
      repeat (2000) step(1'b1, 1'b0);

      // One tick in four: timing stretches, outputs hold between ticks.
      for (int c = 0; c < 3300; c++) step((c % 4) == 0, 1'b0);

      // Synchronous restart landing on x=300 with a coincident tick.
      n = 0;
      while (hp[0] != 299 && n < 1000) begin
         step(1'b1, 1'b0);
         n++;
      end
      if (hp[0] != 299) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sclr_setup got h=%0d want h=299", hp[0]);
      end
      step(1'b1, 1'b1);
      repeat (50) step(1'b1, 1'b0);

      // Random ticks with occasional restarts.
      for (int c = 0; c < 3000; c++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);

      // Asynchronous reset in the middle of the default hsync pulse.
      n = 0;
      while (hp[0] != 700 && n < 1000) begin
         step(1'b1, 1'b0);
         n++;
      end
      if (hp[0] != 700) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rst_setup got h=%0d want h=700", hp[0]);
      end
      @(posedge clk);
      #1;
      advance();
      pe   = 1'b0;
      sclr = 1'b0;
      n_cmp++;
      if (bus0.o_hsync !== 1'b0) begin
         n_bad++;
         $display("FAIL pre_rst_hsync got %b want 0", bus0.o_hsync);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus0.o_hsync !== 1'b1) begin
         n_bad++;
         $display("FAIL async_rst_hsync got %b want 1", bus0.o_hsync);
      end
      for (int i = 0; i < 3; i++) begin
         hp[i] = 0;
         vp[i] = 0;
      end
      push_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_all();
      repeat (500) step(1'($urandom_range(0, 1)), 1'b0);

      repeat (2) @(negedge clk);
      n_cmp++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending want 0", q0.size() + q1.size() + q2.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
